// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter, instruction register, status register and retired-instruction counter
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   rst_f      asynchronous active-low reset
//   pc_rst     synchronous PC clear strobe (highest priority PC update)
//   pc_write   PC update enable
//   pc_sel     0: PC advances by one, 1: PC loads br_target
//   br_sel     1: absolute branch (imm), 0: relative branch (pc_out + imm)
//   ir_load    latch imem_data into the instruction register
//   stat_we    latch stat_in into the status register
//   stat_in    ALU flags {C,V,N,Z}
//   imem_data  instruction word at address pc_out (combinational memory)
//   pc_out     current PC, also the instruction memory address
//   ir         instruction register
//   opcode/mm/rs/rt/rd/imm  fixed slices of ir
//   stat       status register
//   br_target  currently selected branch target
//   instr_cnt  saturating count of IR loads since reset
module fetch_unit #(
    parameter int PC_W  = 16,
    parameter int IR_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_f,
    input  logic             pc_rst,
    input  logic             pc_write,
    input  logic             pc_sel,
    input  logic             br_sel,
    input  logic             ir_load,
    input  logic             stat_we,
    input  logic [3:0]       stat_in,
    input  logic [IR_W-1:0]  imem_data,
    output logic [PC_W-1:0]  pc_out,
    output logic [IR_W-1:0]  ir,
    output logic [3:0]       opcode,
    output logic [3:0]       mm,
    output logic [3:0]       rs,
    output logic [3:0]       rt,
    output logic [3:0]       rd,
    output logic [15:0]      imm,
    output logic [3:0]       stat,
    output logic [PC_W-1:0]  br_target,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [PC_W-1:0] imm_ext;

    // Size cast zero-extends or truncates the 16-bit immediate to the PC width.
    assign imm_ext = PC_W'(imm);

    // Relative targets use the already-incremented PC; the sum wraps modulo 2^PC_W.
    assign br_target = br_sel ? imm_ext : pc_out + imm_ext;

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_out <= '0;
        end else if (pc_rst) begin
            pc_out <= '0;
        end else if (pc_write) begin
            pc_out <= pc_sel ? br_target : pc_out + PC_W'(1);
        end
    end

    // Captures the word at the pre-update PC when fetch also advances pc_out.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            ir <= '0;
        end else if (ir_load) begin
            ir <= imem_data;
        end
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            stat <= '0;
        end else if (stat_we) begin
            stat <= stat_in;
        end
    end

    // Saturates at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            instr_cnt <= '0;
        end else if (ir_load && (instr_cnt != {CNT_W{1'b1}})) begin
            instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign opcode = ir[31:28];
    assign mm     = ir[27:24];
    assign rs     = ir[23:20];
    assign rt     = ir[19:16];
    assign rd     = ir[15:12];
    assign imm    = ir[15:0];

endmodule
